// File: rtl/decode_operand_if.sv
// Handshake and bus bundle between the instruction source, the write-back
// path and the decode/operand stage.
// The master drives instructions, flush and write-back. The slave is the stage.
interface decode_operand_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              flush;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [2:0]        rd_addr;
  logic              rd_we;
  logic              illegal;

  modport master (
    output in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd_addr, rd_we, illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd_addr, rd_we, illegal
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode / operand-fetch stage in front of the 16-bit ALU.
// Decodes one instruction word per accepted handshake. It reads an 8x16
// register file, with write-back bypass, and holds the result in a single
// output register that has no skid buffer.
module decode_operand_stage #(
  parameter int DATA_W   = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  decode_operand_if.slave bus
);

  logic [DATA_W-1:0] regfile_reg [8];

  logic              out_valid_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [2:0]        alu_op_reg;
  logic [2:0]        rd_addr_reg;
  logic              rd_we_reg;
  logic              illegal_reg;

  logic              in_ready_int;
  logic              capture;

  logic [2:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  logic [DATA_W-1:0] alu_a_next;
  logic [DATA_W-1:0] alu_b_next;
  logic [2:0]        alu_op_next;
  logic [2:0]        rd_addr_next;
  logic              rd_we_next;
  logic              illegal_next;

  // Field extraction: the rs2 field overlaps the top of the immediate
  assign op      = bus.in_instr[15:13];
  assign rd      = bus.in_instr[12:10];
  assign rs1     = bus.in_instr[9:7];
  assign rs2     = bus.in_instr[6:4];
  assign imm_ext = {{(DATA_W-7){bus.in_instr[6]}}, bus.in_instr[6:0]};

  // A new word is taken when the output register is empty or is being drained.
  // Flush suppresses the capture but leaves in_ready unchanged.
  assign in_ready_int = !out_valid_reg | bus.out_ready;
  assign capture      = bus.in_valid & in_ready_int & !bus.flush;

  // Operand read with a hard-wired zero r0 and a same-cycle write-back bypass
  always_comb begin
    rs1_val = regfile_reg[rs1];
    rs2_val = regfile_reg[rs2];
    if (ZERO_REG && rs1 == 3'd0)
      rs1_val = '0;
    else if (bus.wb_en && bus.wb_addr == rs1)
      rs1_val = bus.wb_data;
    if (ZERO_REG && rs2 == 3'd0)
      rs2_val = '0;
    else if (bus.wb_en && bus.wb_addr == rs2)
      rs2_val = bus.wb_data;
  end

  // Decode table. Undefined opcodes pass through with zero operands so that
  // the ALU produces 0.
  always_comb begin
    alu_a_next   = '0;
    alu_b_next   = '0;
    alu_op_next  = op;
    rd_addr_next = rd;
    rd_we_next   = 1'b0;
    illegal_next = 1'b0;
    case (op)
      3'b000: begin
        alu_a_next = rs1_val;
        alu_b_next = rs2_val;
        rd_we_next = 1'b1;
      end
      3'b001, 3'b010: begin
        alu_a_next = rs1_val;
        alu_b_next = imm_ext;
        rd_we_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  // Register file write-back. It is independent of the handshake and of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regfile_reg[i] <= '0;
    end else if (bus.wb_en && !(ZERO_REG && bus.wb_addr == 3'd0)) begin
      regfile_reg[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output bundle register. Flush wins over capture, and a drain without
  // refill empties the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rd_addr_reg   <= '0;
      rd_we_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (capture) begin
        out_valid_reg <= 1'b1;
        alu_a_reg     <= alu_a_next;
        alu_b_reg     <= alu_b_next;
        alu_op_reg    <= alu_op_next;
        rd_addr_reg   <= rd_addr_next;
        rd_we_reg     <= rd_we_next;
        illegal_reg   <= illegal_next;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_op    = alu_op_reg;
  assign bus.rd_addr   = rd_addr_reg;
  assign bus.rd_we     = rd_we_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage.
// A reference decode model pushes the expected bundles into a queue at
// capture time. Each cycle the bench compares the held output bundle against
// the head of that queue.
module tb_decode_operand_stage;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic        we;
    logic        ill;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decode_operand_if #(.DATA_W(16)) bus ();

  decode_operand_stage #(.DATA_W(16), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bundle_t     sb_q[$];
  logic        m_ov;
  logic [15:0] m_rf [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] idx);
    if (idx == 3'd0) return 16'h0;
    if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic bundle_t ref_decode(input logic [15:0] ins);
    bundle_t r;
    r.op  = ins[15:13];
    r.rd  = ins[12:10];
    r.a   = 16'h0;
    r.b   = 16'h0;
    r.we  = 1'b0;
    r.ill = 1'b0;
    if (r.op == 3'd0) begin
      r.a  = m_read(ins[9:7]);
      r.b  = m_read(ins[6:4]);
      r.we = 1'b1;
    end else if (r.op == 3'd1 || r.op == 3'd2) begin
      r.a  = m_read(ins[9:7]);
      r.b  = {{9{ins[6]}}, ins[6:0]};
      r.we = 1'b1;
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  // One clock: the model checks and updates at the falling edge, then
  // returns 1 time unit after the rising edge. At that point the caller
  // may change the inputs.
  task automatic cycle();
    logic    m_rdy;
    logic    cap;
    bundle_t h;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      m_ov = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    end else begin
      m_rdy = !m_ov | bus.out_ready;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
      if (m_ov) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          h = sb_q[0];
          chk("alu_a", {16'd0, bus.alu_a}, {16'd0, h.a});
          chk("alu_b", {16'd0, bus.alu_b}, {16'd0, h.b});
          chk("alu_op", {29'd0, bus.alu_op}, {29'd0, h.op});
          chk("rd_addr", {29'd0, bus.rd_addr}, {29'd0, h.rd});
          chk("rd_we", {31'd0, bus.rd_we}, {31'd0, h.we});
          chk("illegal", {31'd0, bus.illegal}, {31'd0, h.ill});
          if (bus.out_ready || bus.flush) begin
            void'(sb_q.pop_front());
            $display("xfer op=%0d rd=%0d a=%h b=%h we=%0b ill=%0b%s", h.op, h.rd, h.a, h.b,
                     h.we, h.ill, (bus.flush && !bus.out_ready) ? " (flushed)" : "");
          end
        end
      end
      cap = bus.in_valid & m_rdy & !bus.flush;
      if (cap) sb_q.push_back(ref_decode(bus.in_instr));
      if (bus.flush) m_ov = 1'b0;
      else if (cap) m_ov = 1'b1;
      else if (bus.out_ready) m_ov = 1'b0;
      if (bus.wb_en && bus.wb_addr != 3'd0) m_rf[bus.wb_addr] = bus.wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ins;
    logic [2:0]  rop;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0;
    bus.flush     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 3'd0;
    bus.wb_data   = 16'h0;
    bus.out_ready = 1'b1;
    m_ov = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;

    // Reset, then idle
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, bus.alu_b}, 32'd0);
    chk("rst_fields", {24'd0, bus.alu_op, bus.rd_addr, bus.rd_we, bus.illegal}, 32'd0);
    cycle();

    // ADD r1, r2, r3 on a freshly cleared register file
    bus.in_instr = {3'b000, 3'd1, 3'd2, 3'd3, 4'b0};
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("add0_a", {16'd0, bus.alu_a}, 32'd0);
    chk("add0_b", {16'd0, bus.alu_b}, 32'd0);
    cycle();

    // Write r2 = 0x1234, then ADDI r1, r2, -1
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h1234;
    cycle();
    bus.wb_en = 1'b0;
    bus.in_instr = 16'b001_001_010_1111111;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("addi_a", {16'd0, bus.alu_a}, 32'h1234);
    chk("addi_b", {16'd0, bus.alu_b}, 32'hFFFF);
    chk("addi_op", {29'd0, bus.alu_op}, 32'd1);
    chk("addi_rd", {29'd0, bus.rd_addr}, 32'd1);
    chk("addi_we", {31'd0, bus.rd_we}, 32'd1);

    // Bypass: write r3 = 0x00AA in the capture cycle of ADD r4, r3, r3
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h00AA;
    bus.in_instr = {3'b000, 3'd4, 3'd3, 3'd3, 4'b0};
    bus.in_valid = 1'b1;
    cycle();
    chk("byp_a", {16'd0, bus.alu_a}, 32'h00AA);
    chk("byp_b", {16'd0, bus.alu_b}, 32'h00AA);
    // A write-back to r0 must not be bypassed
    bus.wb_addr = 3'd0; bus.wb_data = 16'h5555;
    bus.in_instr = {3'b000, 3'd4, 3'd0, 3'd0, 4'b0};
    cycle();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b0;
    chk("byp_r0_a", {16'd0, bus.alu_a}, 32'd0);
    chk("byp_r0_b", {16'd0, bus.alu_b}, 32'd0);
    cycle();

    // Backpressure: hold the first bundle for 3 cycles with a second word waiting
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = {3'b001, 3'd5, 3'd2, 7'd5};
    cycle();
    bus.in_instr  = {3'b000, 3'd6, 3'd2, 3'd3, 4'b0};
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_a", {16'd0, bus.alu_a}, 32'h1234);
      chk("bp_hold_b", {16'd0, bus.alu_b}, 32'h0005);
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("bp_second_rd", {29'd0, bus.rd_addr}, 32'd6);
    chk("bp_second_b", {16'd0, bus.alu_b}, 32'h00AA);
    cycle();

    // Undefined opcode
    bus.in_instr = {3'b101, 3'd2, 3'd2, 3'd3, 4'b0};
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
    chk("ill_we", {31'd0, bus.rd_we}, 32'd0);
    chk("ill_op", {29'd0, bus.alu_op}, 32'd5);
    chk("ill_a", {16'd0, bus.alu_a}, 32'd0);

    // Flush with a valid word offered: the word must not be captured
    bus.in_instr = {3'b000, 3'd7, 3'd2, 3'd2, 4'b0};
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_ov", {31'd0, bus.out_valid}, 32'd0);
    cycle();

    // Streaming random legal instructions with random write-back traffic
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 2));
      ins = 16'($urandom);
      ins[15:13] = rop;
      bus.in_instr = ins;
      bus.wb_en    = 1'($urandom_range(0, 1));
      bus.wb_addr  = 3'($urandom_range(0, 7));
      bus.wb_data  = 16'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    cycle();
    cycle();
    chk("drain_q", sb_q.size(), 32'd0);

    // Reset in the middle of a held transfer
    bus.out_ready = 1'b0;
    bus.in_instr  = {3'b001, 3'd1, 3'd0, 7'd5};
    bus.in_valid  = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_b", {16'd0, bus.alu_b}, 32'd0);
    cycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'd0, bus.in_ready}, 32'd1);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
